mbus_sleep_req_gen: RTL and testbench

Sleep-request qualifier that sits directly upstream of the MBus regular sleep controller and drives its SLEEP_REQ input. It collects sleep requests from the bus controller (broadcast sleep message) and from the layer controller. It waits for a guaranteed quiet period on the bus, then holds SLEEP_REQ until the sleep controller confirms power-gating through BC_PG_CLR_BUSY. It also supports wake-up abort before commit and flags acknowledge timeouts.

---
 rtl/mbus_sleep_req_gen.sv | 138 +++++++++++++
 tb/tb_mbus_sleep_req_gen.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mbus_sleep_req_gen.sv
// Sleep-request qualifier in front of the MBus sleep controller. It waits for a quiet bus,
// holds SLEEP_REQ until power-gating is confirmed, and reports done, abort or timeout.
module mbus_sleep_req_gen #(
  parameter int IDLE_CYCLES = 4,
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       CLKIN,
  input  logic       RESETn,
  input  logic       BUS_SLEEP_MSG,
  input  logic       LC_SLEEP_REQ,
  input  logic       BUS_BUSY,
  input  logic       WAKEUP_REQ,
  input  logic       PG_CLR_BUSY,
  output logic       SLEEP_REQ,
  output logic [1:0] SLEEP_SRC,
  output logic       SLEEP_DONE,
  output logic       SLEEP_ABORT,
  output logic       SLEEP_ERR
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_QUALIFY = 2'd1,
    S_REQ     = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       src_q, src_d;
  logic             req_q, req_d;
  logic             done_q, done_d;
  logic             abort_q, abort_d;
  logic             err_q, err_d;

  always_ff @(posedge CLKIN or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      src_q   <= 2'b00;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      req_q   <= req_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end

  // Outputs are computed for the state being entered, so every output is a plain flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    req_d   = 1'b0;
    done_d  = 1'b0;
    abort_d = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if ((BUS_SLEEP_MSG || LC_SLEEP_REQ) && !WAKEUP_REQ) begin
          state_d = S_QUALIFY;
          src_d   = {LC_SLEEP_REQ, BUS_SLEEP_MSG};
        end
      end

      S_QUALIFY: begin
        if (WAKEUP_REQ) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          src_d   = 2'b00;
          abort_d = 1'b1;
        end else begin
          src_d = src_q | {LC_SLEEP_REQ, BUS_SLEEP_MSG};
          if (BUS_BUSY) begin
            cnt_d = '0;
          end else if (cnt_q == IDLE_LAST) begin
            state_d = S_REQ;
            cnt_d   = '0;
            req_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      // Committed: wake-up no longer cancels; an acknowledge beats a simultaneous timeout.
      S_REQ: begin
        if (PG_CLR_BUSY) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else if (cnt_q == ACK_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          src_d   = 2'b00;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          req_d = 1'b1;
        end
      end

      S_DRAIN: begin
        cnt_d = '0;
        if (!PG_CLR_BUSY) begin
          state_d = S_IDLE;
          src_d   = 2'b00;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        src_d   = 2'b00;
      end
    endcase
  end

  assign SLEEP_REQ   = req_q;
  assign SLEEP_SRC   = src_q;
  assign SLEEP_DONE  = done_q;
  assign SLEEP_ABORT = abort_q;
  assign SLEEP_ERR   = err_q;

endmodule

// File: tb/tb_mbus_sleep_req_gen.sv
// Bench for mbus_sleep_req_gen: per-cycle expected outputs {REQ,SRC[1:0],DONE,ABORT,ERR}
// are queued as stimulus is applied and compared after the following clock edge.
module tb_mbus_sleep_req_gen;

  logic       CLKIN = 1'b0;
  logic       RESETn;
  logic       BUS_SLEEP_MSG, LC_SLEEP_REQ, BUS_BUSY, WAKEUP_REQ, PG_CLR_BUSY;
  logic       SLEEP_REQ;
  logic [1:0] SLEEP_SRC;
  logic       SLEEP_DONE, SLEEP_ABORT, SLEEP_ERR;

  int errors = 0;
  int checks = 0;
  logic [5:0] exp_q[$];

  // Input encoding {MSG, LC, BUSY, WAKE, PG}
  localparam logic [4:0] I_NONE = 5'b00000;
  localparam logic [4:0] I_MSG  = 5'b10000;
  localparam logic [4:0] I_LC   = 5'b01000;
  localparam logic [4:0] I_BUSY = 5'b00100;
  localparam logic [4:0] I_WAKE = 5'b00010;
  localparam logic [4:0] I_PG   = 5'b00001;

  always #5 CLKIN = ~CLKIN;

  mbus_sleep_req_gen #(.IDLE_CYCLES(4), .ACK_TIMEOUT(16), .CNT_W(5)) dut (
    .CLKIN        (CLKIN),
    .RESETn       (RESETn),
    .BUS_SLEEP_MSG(BUS_SLEEP_MSG),
    .LC_SLEEP_REQ (LC_SLEEP_REQ),
    .BUS_BUSY     (BUS_BUSY),
    .WAKEUP_REQ   (WAKEUP_REQ),
    .PG_CLR_BUSY  (PG_CLR_BUSY),
    .SLEEP_REQ    (SLEEP_REQ),
    .SLEEP_SRC    (SLEEP_SRC),
    .SLEEP_DONE   (SLEEP_DONE),
    .SLEEP_ABORT  (SLEEP_ABORT),
    .SLEEP_ERR    (SLEEP_ERR)
  );

  function automatic logic [5:0] outs();
    return {SLEEP_REQ, SLEEP_SRC, SLEEP_DONE, SLEEP_ABORT, SLEEP_ERR};
  endfunction

  // Apply one cycle of inputs, queue what must appear after the edge, then step past the edge.
  task automatic drive(input logic [4:0] in, input logic [5:0] exp);
    {BUS_SLEEP_MSG, LC_SLEEP_REQ, BUS_BUSY, WAKEUP_REQ, PG_CLR_BUSY} = in;
    exp_q.push_back(exp);
    @(posedge CLKIN);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] e;
    RESETn = 1'b0;
    {BUS_SLEEP_MSG, LC_SLEEP_REQ, BUS_BUSY, WAKEUP_REQ, PG_CLR_BUSY} = I_LC;
    #3;
    exp_q.push_back(6'b0_00_000);
    e = exp_q.pop_front();
    checks++;
    if (outs() !== e) begin
      errors++;
      $display("FAIL reset_async: got %b expected %b", outs(), e);
    end
    @(posedge CLKIN);
    @(posedge CLKIN);
    #1;
    exp_q.push_back(6'b0_00_000);
    e = exp_q.pop_front();
    checks++;
    if (outs() !== e) begin
      errors++;
      $display("FAIL reset_held: got %b expected %b", outs(), e);
    end
    RESETn = 1'b1;
  endtask

  task automatic test_lc_basic(input string name);
    logic [4:0] st[8] = '{I_LC, I_NONE, I_NONE, I_NONE, I_NONE, I_PG, I_NONE, I_NONE};
    logic [5:0] ex[8] = '{6'b0_10_000, 6'b0_10_000, 6'b0_10_000, 6'b0_10_000,
                          6'b1_10_000, 6'b0_10_100, 6'b0_00_000, 6'b0_00_000};
    logic [5:0] e;
    for (int i = 0; i < 8; i++) begin
      drive(st[i], ex[i]);
      e = exp_q.pop_front();
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL %s cyc %0d: got %b expected %b", name, i, outs(), e);
      end
    end
  endtask

  task automatic test_busy_restart();
    logic [4:0] st[12] = '{I_MSG, I_NONE, I_NONE, I_NONE, I_BUSY, I_NONE, I_NONE, I_NONE,
                           I_NONE, I_PG, I_PG, I_NONE};
    logic [5:0] ex[12] = '{6'b0_01_000, 6'b0_01_000, 6'b0_01_000, 6'b0_01_000,
                           6'b0_01_000, 6'b0_01_000, 6'b0_01_000, 6'b0_01_000,
                           6'b1_01_000, 6'b0_01_100, 6'b0_01_000, 6'b0_00_000};
    logic [5:0] e;
    for (int i = 0; i < 12; i++) begin
      drive(st[i], ex[i]);
      e = exp_q.pop_front();
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL busy_restart cyc %0d: got %b expected %b", i, outs(), e);
      end
    end
  endtask

  task automatic test_abort();
    logic [4:0] st[5] = '{I_MSG, I_NONE, I_WAKE, I_WAKE, I_NONE};
    logic [5:0] ex[5] = '{6'b0_01_000, 6'b0_01_000, 6'b0_00_010, 6'b0_00_000, 6'b0_00_000};
    logic [5:0] e;
    for (int i = 0; i < 5; i++) begin
      drive(st[i], ex[i]);
      e = exp_q.pop_front();
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL abort cyc %0d: got %b expected %b", i, outs(), e);
      end
    end
  endtask

  task automatic test_wake_idle_and_req();
    logic [4:0] st[11] = '{I_MSG | I_WAKE, I_LC | I_WAKE, I_LC, I_MSG, I_NONE, I_NONE,
                           I_NONE, I_WAKE, I_WAKE | I_MSG, I_PG, I_NONE};
    logic [5:0] ex[11] = '{6'b0_00_000, 6'b0_00_000, 6'b0_10_000, 6'b0_11_000,
                           6'b0_11_000, 6'b0_11_000, 6'b1_11_000, 6'b1_11_000,
                           6'b1_11_000, 6'b0_11_100, 6'b0_00_000};
    logic [5:0] e;
    for (int i = 0; i < 11; i++) begin
      drive(st[i], ex[i]);
      e = exp_q.pop_front();
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL wake_idle_req cyc %0d: got %b expected %b", i, outs(), e);
      end
    end
  endtask

  // REQ is entered on cycle 4; cycles 5..20 are the 16 REQ cycles, timeout decided on cycle 20.
  task automatic test_timeout(input bit pg_on_last);
    logic [4:0] in;
    logic [5:0] ex;
    logic [5:0] e;
    for (int i = 0; i < 22; i++) begin
      in = (i == 0) ? I_LC : ((i == 20 && pg_on_last) ? I_PG : I_NONE);
      if (i < 4)       ex = 6'b0_10_000;
      else if (i < 20) ex = 6'b1_10_000;
      else if (i == 20) ex = pg_on_last ? 6'b0_10_100 : 6'b0_00_001;
      else             ex = 6'b0_00_000;
      drive(in, ex);
      e = exp_q.pop_front();
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL timeout(pg=%0d) cyc %0d: got %b expected %b", pg_on_last, i, outs(), e);
      end
    end
  endtask

  task automatic test_reset_mid_req();
    logic [5:0] e;
    for (int i = 0; i < 6; i++) begin
      drive((i == 0) ? I_LC : I_NONE, (i < 4) ? 6'b0_10_000 : 6'b1_10_000);
      e = exp_q.pop_front();
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL reset_mid_req enter cyc %0d: got %b expected %b", i, outs(), e);
      end
    end
    RESETn = 1'b0;
    #2;
    exp_q.push_back(6'b0_00_000);
    e = exp_q.pop_front();
    checks++;
    if (outs() !== e) begin
      errors++;
      $display("FAIL reset_mid_req async: got %b expected %b", outs(), e);
    end
    @(posedge CLKIN);
    #1;
    exp_q.push_back(6'b0_00_000);
    e = exp_q.pop_front();
    checks++;
    if (outs() !== e) begin
      errors++;
      $display("FAIL reset_mid_req held: got %b expected %b", outs(), e);
    end
    RESETn = 1'b1;
    test_lc_basic("after_reset");
  endtask

  initial begin
    RESETn = 1'b0;
    {BUS_SLEEP_MSG, LC_SLEEP_REQ, BUS_BUSY, WAKEUP_REQ, PG_CLR_BUSY} = I_NONE;
    test_reset();
    test_lc_basic("lc_basic");
    test_busy_restart();
    test_abort();
    test_wake_idle_and_req();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
